windowed_register_file: RTL and testbench



---
 rtl/sparc_rf_pkg.sv | 16 +
 rtl/reg_window_map.sv | 32 +++
 rtl/windowed_register_file.sv | 139 +++++++++++++
 tb/tb_windowed_register_file.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sparc_rf_pkg.sv
// Shared constants, FSM encoding and sizing helper for the windowed register file.
package sparc_rf_pkg;

  localparam int NGLOBALS        = 8;
  localparam int REGS_PER_WINDOW = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } rf_state_e;

  function automatic int nphys(input int nwindows);
    return NGLOBALS + REGS_PER_WINDOW * nwindows;
  endfunction

endpackage

// File: rtl/reg_window_map.sv
// Translates an architectural register number plus CWP into a physical register index.
module reg_window_map
  import sparc_rf_pkg::*;
#(
  parameter int NWINDOWS = 8,
  parameter int CWP_W    = 3,
  parameter int PIDX_W   = 8
) (
  input  logic [4:0]        arch_addr,
  input  logic [CWP_W-1:0]  cwp,
  output logic [PIDX_W-1:0] phys_idx
);

  localparam logic [PIDX_W:0] WIN_REGS = (PIDX_W+1)'(REGS_PER_WINDOW * NWINDOWS);
  localparam logic [PIDX_W:0] GLOBALS  = (PIDX_W+1)'(NGLOBALS);

  logic [PIDX_W:0] off;

  // The unwrapped offset is below twice the windowed region, so one subtract wraps it.
  always_comb begin
    off = ((PIDX_W+1)'(cwp) << 4) + (PIDX_W+1)'(arch_addr) - GLOBALS;
    if (off >= WIN_REGS) begin
      off = off - WIN_REGS;
    end
    if (arch_addr < 5'(NGLOBALS)) begin
      phys_idx = PIDX_W'(arch_addr);
    end else begin
      phys_idx = PIDX_W'(off + GLOBALS);
    end
  end

endmodule

// File: rtl/windowed_register_file.sv
// SPARC-style windowed register file with overlapping windows, trap pulses and a clear sweep.
module windowed_register_file
  import sparc_rf_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int NWINDOWS = 8,
  localparam int CWP_W    = $clog2(NWINDOWS),
  localparam int NPHYS    = NGLOBALS + REGS_PER_WINDOW * NWINDOWS
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic [4:0]        in_PA,
  input  logic [4:0]        in_PB,
  input  logic [4:0]        in_PC,
  input  logic [DATA_W-1:0] data_in,
  input  logic              register_file_enable,
  input  logic              save,
  input  logic              restore,
  input  logic [NWINDOWS-1:0] wim_in,
  input  logic              cwp_load,
  input  logic [CWP_W-1:0]  cwp_in,
  input  logic              clear_req,
  output logic [DATA_W-1:0] out_PA,
  output logic [DATA_W-1:0] out_PB,
  output logic [CWP_W-1:0]  cwp_out,
  output logic              window_overflow,
  output logic              window_underflow,
  output logic              busy
);

  localparam int PIDX_W = $clog2(nphys(NWINDOWS));
  localparam logic [PIDX_W-1:0] CNT_LAST = PIDX_W'(NPHYS - 1);
  localparam logic [CWP_W-1:0]  CWP_MAX  = CWP_W'(NWINDOWS - 1);
  localparam logic [CWP_W:0]    NW_V     = (CWP_W+1)'(NWINDOWS);

  logic [DATA_W-1:0] regs_q [NPHYS];

  rf_state_e         state_q, state_d;
  logic [PIDX_W-1:0] cnt_q, cnt_d;
  logic [CWP_W-1:0]  cwp_q, cwp_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic [PIDX_W-1:0] pa_idx, pb_idx, pc_idx;
  logic              wr_en;
  logic [PIDX_W-1:0] wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [CWP_W-1:0]  cwp_dec, cwp_inc, cwp_ld;

  reg_window_map #(.NWINDOWS(NWINDOWS), .CWP_W(CWP_W), .PIDX_W(PIDX_W)) u_map_a (
    .arch_addr(in_PA), .cwp(cwp_q), .phys_idx(pa_idx)
  );
  reg_window_map #(.NWINDOWS(NWINDOWS), .CWP_W(CWP_W), .PIDX_W(PIDX_W)) u_map_b (
    .arch_addr(in_PB), .cwp(cwp_q), .phys_idx(pb_idx)
  );
  reg_window_map #(.NWINDOWS(NWINDOWS), .CWP_W(CWP_W), .PIDX_W(PIDX_W)) u_map_c (
    .arch_addr(in_PC), .cwp(cwp_q), .phys_idx(pc_idx)
  );

  assign busy             = (state_q == ST_CLEAR);
  assign cwp_out          = cwp_q;
  assign window_overflow  = ovf_q;
  assign window_underflow = unf_q;

  // Reads see only registered contents, so a same-cycle write is not forwarded.
  assign out_PA = (busy || in_PA == 5'd0) ? '0 : regs_q[pa_idx];
  assign out_PB = (busy || in_PB == 5'd0) ? '0 : regs_q[pb_idx];

  assign cwp_dec = (cwp_q == '0) ? CWP_MAX : cwp_q - CWP_W'(1);
  assign cwp_inc = (cwp_q == CWP_MAX) ? '0 : cwp_q + CWP_W'(1);
  assign cwp_ld  = ({1'b0, cwp_in} >= NW_V) ? CWP_W'({1'b0, cwp_in} - NW_V) : cwp_in;

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = pc_idx;
    wr_data = data_in;
    if (!Clr) begin
      if (state_q == ST_CLEAR) begin
        wr_en   = 1'b1;
        wr_idx  = cnt_q;
        wr_data = '0;
      end else if (register_file_enable && in_PC != 5'd0) begin
        wr_en = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cwp_d   = cwp_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + PIDX_W'(1);
      if (cnt_q == CNT_LAST) begin
        state_d = ST_IDLE;
      end
    end else begin
      if (clear_req) begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
      if (cwp_load) begin
        cwp_d = cwp_ld;
      end else if (save && !restore) begin
        if (wim_in[cwp_dec]) ovf_d = 1'b1;
        else                 cwp_d = cwp_dec;
      end else if (restore && !save) begin
        if (wim_in[cwp_inc]) unf_d = 1'b1;
        else                 cwp_d = cwp_inc;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      cwp_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cwp_q   <= cwp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage carries no reset; the clear sweep is what zeroes it.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      regs_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_windowed_register_file.sv
// Bench for windowed_register_file: directed vector table, clear-sweep sequences, random vs. model.
module tb_windowed_register_file;

  localparam int NW    = 8;
  localparam int NPH   = 8 + 16 * NW;
  localparam int CW    = $clog2(NW);

  logic          Clk, Clr;
  logic [4:0]    in_PA, in_PB, in_PC;
  logic [31:0]   data_in;
  logic          register_file_enable, save, restore, cwp_load, clear_req;
  logic [NW-1:0] wim_in;
  logic [CW-1:0] cwp_in;
  logic [31:0]   out_PA, out_PB;
  logic [CW-1:0] cwp_out;
  logic          window_overflow, window_underflow, busy;

  windowed_register_file #(.DATA_W(32), .NWINDOWS(NW)) dut (
    .Clk(Clk), .Clr(Clr), .in_PA(in_PA), .in_PB(in_PB), .in_PC(in_PC),
    .data_in(data_in), .register_file_enable(register_file_enable),
    .save(save), .restore(restore), .wim_in(wim_in), .cwp_load(cwp_load),
    .cwp_in(cwp_in), .clear_req(clear_req), .out_PA(out_PA), .out_PB(out_PB),
    .cwp_out(cwp_out), .window_overflow(window_overflow),
    .window_underflow(window_underflow), .busy(busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic          clr, creq, ld, sv, rs, we;
    logic [CW-1:0] cin;
    logic [NW-1:0] wim;
    logic [4:0]    pa, pb, pc;
    logic [31:0]   data;
    logic [CW-1:0] e_cwp;
    logic          e_ov, e_un;
    logic [31:0]   e_a, e_b;
  } vec_t;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  // Reference model: architectural view of physical storage and window state.
  logic [31:0] mem [NPH];
  int m_cwp = 0;
  bit m_ov = 0, m_un = 0;
  int clr_left = 0, clr_pos = 0;

  function automatic int phys(input int r, input int c);
    if (r < 8) return r;
    return 8 + (c * 16 + r - 8) % (16 * NW);
  endfunction

  function automatic logic [31:0] m_read(input int r);
    if (clr_left > 0 || r == 0) return 32'd0;
    return mem[phys(r, m_cwp)];
  endfunction

  function automatic vec_t mk(input logic ld, input int cin, input logic sv, input logic rs,
                              input logic [NW-1:0] wim, input logic we, input int pc,
                              input logic [31:0] data, input int pa, input int pb,
                              input int ecwp, input logic eov, input logic eun,
                              input logic [31:0] ea, input logic [31:0] eb);
    vec_t v;
    v.clr = 0; v.creq = 0; v.ld = ld; v.cin = CW'(cin); v.sv = sv; v.rs = rs;
    v.wim = wim; v.we = we; v.pc = 5'(pc); v.data = data; v.pa = 5'(pa); v.pb = 5'(pb);
    v.e_cwp = CW'(ecwp); v.e_ov = eov; v.e_un = eun; v.e_a = ea; v.e_b = eb;
    return v;
  endfunction

  function automatic vec_t idle(input int pa, input int pb);
    return mk(0, 0, 0, 0, '0, 0, 0, 0, pa, pb, 0, 0, 0, 0, 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input vec_t v);
    if (v.clr) begin
      m_cwp = 0; clr_left = NPH; clr_pos = 0; m_ov = 0; m_un = 0;
    end else if (clr_left > 0) begin
      mem[clr_pos] = 32'd0; clr_pos++; clr_left--; m_ov = 0; m_un = 0;
    end else begin
      m_ov = 0; m_un = 0;
      if (v.we && v.pc != 0) mem[phys(v.pc, m_cwp)] = v.data;
      if (v.creq) begin clr_left = NPH; clr_pos = 0; end
      if (v.ld) m_cwp = int'(v.cin) % NW;
      else if (v.sv && !v.rs) begin
        if (v.wim[(m_cwp + NW - 1) % NW]) m_ov = 1;
        else m_cwp = (m_cwp + NW - 1) % NW;
      end else if (v.rs && !v.sv) begin
        if (v.wim[(m_cwp + 1) % NW]) m_un = 1;
        else m_cwp = (m_cwp + 1) % NW;
      end
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'(clr_left > 0));
    chk({tag, "_cwp"}, 32'(cwp_out), 32'(m_cwp));
    chk({tag, "_ovf"}, 32'(window_overflow), 32'(m_ov));
    chk({tag, "_unf"}, 32'(window_underflow), 32'(m_un));
    chk({tag, "_outA"}, out_PA, m_read(int'(in_PA)));
    chk({tag, "_outB"}, out_PB, m_read(int'(in_PB)));
  endtask

  // One clock: drive, check reads before the edge (no bypass), advance model, check after.
  task automatic step(input vec_t v, input bit use_exp, input string name);
    Clr = v.clr; clear_req = v.creq; cwp_load = v.ld; cwp_in = v.cin;
    save = v.sv; restore = v.rs; wim_in = v.wim; register_file_enable = v.we;
    in_PC = v.pc; data_in = v.data; in_PA = v.pa; in_PB = v.pb;
    @(negedge Clk);
    if (chk_en) cmp_model({name, "_pre"});
    @(posedge Clk);
    model_step(v);
    if (v.clr) chk_en = 1;
    #1;
    Clr = 0; clear_req = 0; cwp_load = 0; save = 0; restore = 0; register_file_enable = 0;
    if (chk_en) cmp_model({name, "_post"});
    if (use_exp) begin
      chk({name, "_cwp_exp"}, 32'(cwp_out), 32'(v.e_cwp));
      chk({name, "_ovf_exp"}, 32'(window_overflow), 32'(v.e_ov));
      chk({name, "_unf_exp"}, 32'(window_underflow), 32'(v.e_un));
      chk({name, "_busy_exp"}, 32'(busy), 32'd0);
      chk({name, "_outA_exp"}, out_PA, v.e_a);
      chk({name, "_outB_exp"}, out_PB, v.e_b);
    end
  endtask

  task automatic busy_len(input vec_t v, input int expect_len, input string name);
    int n;
    n = 0;
    while (busy && n < 400) begin
      step(v, 0, name);
      n++;
    end
    chk({name, "_len"}, 32'(n), 32'(expect_len));
  endtask

  vec_t tbl [26];
  vec_t v;

  initial begin
    for (int i = 0; i < NPH; i++) mem[i] = 32'd0;
    Clr = 0; clear_req = 0; cwp_load = 0; cwp_in = '0; save = 0; restore = 0;
    wim_in = '0; register_file_enable = 0; in_PA = 0; in_PB = 0; in_PC = 0; data_in = 0;
    @(posedge Clk); #1;

    // Reset and first sweep.
    v = idle(1, 24); v.clr = 1;
    step(v, 0, "reset");
    chk("reset_busy", 32'(busy), 32'd1);
    chk("reset_cwp", 32'(cwp_out), 32'd0);
    busy_len(idle(1, 24), NPH, "sweep1");

    //         ld cin sv rs wim    we pc data          pa  pb  cwp ov un  outA          outB
    tbl[0]  = mk(1, 3, 0, 0, 8'h00, 0, 0, 0,           0,  0,  3, 0, 0, 0,            0);
    tbl[1]  = mk(0, 0, 0, 0, 8'h00, 1, 8, 32'hA5A5A5A5, 8,  0,  3, 0, 0, 32'hA5A5A5A5, 0);
    tbl[2]  = mk(0, 0, 1, 0, 8'h00, 0, 0, 0,           24, 8,  2, 0, 0, 32'hA5A5A5A5, 0);
    tbl[3]  = mk(1, 0, 0, 0, 8'h00, 0, 0, 0,           0,  0,  0, 0, 0, 0,            0);
    tbl[4]  = mk(0, 0, 1, 0, 8'h80, 0, 0, 0,           0,  0,  0, 1, 0, 0,            0);
    tbl[5]  = mk(0, 0, 0, 0, 8'h80, 0, 0, 0,           0,  0,  0, 0, 0, 0,            0);
    tbl[6]  = mk(1, 7, 0, 0, 8'h00, 0, 0, 0,           0,  0,  7, 0, 0, 0,            0);
    tbl[7]  = mk(0, 0, 0, 1, 8'h00, 0, 0, 0,           0,  0,  0, 0, 0, 0,            0);
    tbl[8]  = mk(1, 7, 0, 0, 8'h00, 0, 0, 0,           0,  0,  7, 0, 0, 0,            0);
    tbl[9]  = mk(0, 0, 0, 1, 8'h01, 0, 0, 0,           0,  0,  7, 0, 1, 0,            0);
    tbl[10] = mk(0, 0, 0, 0, 8'h01, 0, 0, 0,           0,  0,  7, 0, 0, 0,            0);
    tbl[11] = mk(0, 0, 0, 0, 8'h00, 1, 1, 5,           1,  0,  7, 0, 0, 5,            0);
    tbl[12] = mk(0, 0, 0, 0, 8'h00, 1, 0, 9,           0,  1,  7, 0, 0, 0,            5);
    tbl[13] = mk(1, 2, 0, 0, 8'h00, 0, 0, 0,           1,  0,  2, 0, 0, 5,            0);
    tbl[14] = mk(1, 5, 0, 0, 8'h00, 0, 0, 0,           1,  0,  5, 0, 0, 5,            0);
    tbl[15] = mk(1, 3, 0, 0, 8'h00, 0, 0, 0,           0,  0,  3, 0, 0, 0,            0);
    tbl[16] = mk(0, 0, 1, 1, 8'hFF, 0, 0, 0,           0,  0,  3, 0, 0, 0,            0);
    tbl[17] = mk(1, 6, 1, 0, 8'h00, 0, 0, 0,           0,  0,  6, 0, 0, 0,            0);
    tbl[18] = mk(1, 1, 1, 0, 8'hFF, 0, 0, 0,           0,  0,  1, 0, 0, 0,            0);
    tbl[19] = mk(0, 0, 1, 0, 8'h00, 0, 0, 0,           0,  0,  0, 0, 0, 0,            0);
    tbl[20] = mk(0, 0, 1, 0, 8'h00, 0, 0, 0,           0,  0,  7, 0, 0, 0,            0);
    tbl[21] = mk(0, 0, 0, 0, 8'h00, 1, 24, 32'h1234,   24, 0,  7, 0, 0, 32'h1234,     0);
    tbl[22] = mk(0, 0, 0, 1, 8'h00, 0, 0, 0,           8,  24, 0, 0, 0, 32'h1234,     0);
    tbl[23] = mk(1, 1, 0, 0, 8'h00, 0, 0, 0,           1,  8,  1, 0, 0, 5,            0);
    tbl[24] = mk(1, 4, 0, 0, 8'h00, 1, 8, 32'hBEEF,    8,  1,  4, 0, 0, 0,            5);
    tbl[25] = mk(1, 1, 0, 0, 8'h00, 0, 0, 0,           8,  24, 1, 0, 0, 32'hBEEF,     0);
    for (int i = 0; i < 26; i++) step(tbl[i], 1, $sformatf("vec%0d", i));

    // Clr in the middle of a sweep restarts it; save while busy is ignored.
    v = idle(1, 8); v.creq = 1;
    step(v, 0, "creq");
    chk("creq_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 50; i++) step(idle(1, 8), 0, "mid");
    v = idle(1, 8); v.clr = 1;
    step(v, 0, "reclr");
    v = idle(1, 8); v.sv = 1;
    busy_len(v, NPH, "sweep2");
    chk("sweep2_cwp", 32'(cwp_out), 32'd0);
    chk("sweep2_r1", out_PA, 32'd0);
    chk("sweep2_r8", out_PB, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      v = idle(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      v.clr  = ($urandom_range(0, 299) == 0);
      v.creq = ($urandom_range(0, 199) == 0);
      v.ld   = ($urandom_range(0, 5) == 0);
      v.cin  = CW'($urandom);
      v.sv   = ($urandom_range(0, 2) == 0);
      v.rs   = ($urandom_range(0, 2) == 0);
      v.wim  = NW'($urandom & $urandom & $urandom);
      v.we   = ($urandom_range(0, 1) == 0);
      v.pc   = 5'($urandom);
      v.data = $urandom;
      step(v, 0, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
